// File: rtl/noc_arb_pkg.sv
// Shared definitions for the NoC output arbiter: FSM states, Avalon register
// map, status bit positions and a small index helper.
package noc_arb_pkg;

  typedef enum logic {
    IDLE   = 1'b0,
    STREAM = 1'b1
  } arb_state_t;

  localparam logic [1:0] ADDR_MASK   = 2'd0;
  localparam logic [1:0] ADDR_STATUS = 2'd1;
  localparam logic [1:0] ADDR_STATS  = 2'd2;

  localparam int STATUS_BUSY_BIT   = 31;
  localparam int STATUS_OVALID_BIT = 30;

  // Successor of idx in a ring of n positions.
  function automatic int wrap_inc(input int idx, input int n);
    return (idx + 1 == n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/noc_rr_pick.sv
// Combinational round-robin pick: first set bit of req at or after start,
// wrapping around.
module noc_rr_pick #(
  parameter int N     = 4,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [IDX_W-1:0] start,
  output logic             found,
  output logic [IDX_W-1:0] idx
);

  logic [IDX_W-1:0] cand [N];

  always_comb begin
    for (int k = 0; k < N; k++) begin
      cand[k] = IDX_W'((int'(start) + k) % N);
    end
  end

  // Scanning from the far end lets the candidate closest to start win.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (req[cand[k]]) begin
        found = 1'b1;
        idx   = cand[k];
      end
    end
  end

endmodule

// File: rtl/noc_out_arbiter.sv
// Packet-locked round-robin arbiter sharing one registered NoC word port.
// Define NOC_ARB_STATS_EN to add the delivered-word counter at address 2.
module noc_out_arbiter
  import noc_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 32,
  parameter int IDX_W   = $clog2(NUM_REQ)
) (
  input  logic                      clk,
  input  logic                      reset_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  input  logic [NUM_REQ-1:0]        req_last,
  output logic [NUM_REQ-1:0]        req_ready,
  output logic [DATA_W-1:0]         out_port,
  output logic                      out_valid,
  input  logic                      out_ready,
  input  logic [1:0]                address,
  input  logic                      chipselect,
  input  logic                      write_n,
  input  logic [31:0]               writedata,
  output logic [31:0]               readdata
);

  arb_state_t         state, state_nxt;
  logic [IDX_W-1:0]   grant, last_grant;
  logic [IDX_W-1:0]   pick_start, pick_idx;
  logic               pick_found;
  logic [NUM_REQ-1:0] mask;
  logic [DATA_W-1:0]  grant_data;
  logic               can_load, accept, pkt_done;
  logic               reg_write;
  logic [31:0]        stats_rd;

  assign pick_start = IDX_W'(wrap_inc(int'(last_grant), NUM_REQ));

  noc_rr_pick #(
    .N     (NUM_REQ),
    .IDX_W (IDX_W)
  ) u_pick (
    .req   (req_valid & mask),
    .start (pick_start),
    .found (pick_found),
    .idx   (pick_idx)
  );

  assign grant_data = req_data[int'(grant)*DATA_W +: DATA_W];
  // The output register can take a word when empty or draining this cycle.
  assign can_load   = !out_valid || out_ready;
  assign accept     = (state == STREAM) && req_valid[grant] && can_load;
  assign pkt_done   = accept && req_last[grant];
  assign reg_write  = chipselect && !write_n;

  // NOTE: every output of a combinational block gets a default before any
  // condition, otherwise the unassigned paths infer latches.
  always_comb begin
    req_ready = '0;
    if (state == STREAM) begin
      req_ready[grant] = can_load;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (pick_found) state_nxt = STREAM;
      STREAM:  if (pkt_done)   state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant is only ever loaded in IDLE, which is what locks it for a packet.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      grant      <= '0;
      last_grant <= IDX_W'(NUM_REQ - 1);
    end else begin
      if (state == IDLE && pick_found) begin
        grant <= pick_idx;
      end
      if (pkt_done) begin
        last_grant <= grant;
      end
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      out_port  <= '0;
      out_valid <= 1'b0;
    end else if (accept) begin
      out_port  <= grant_data;
      out_valid <= 1'b1;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mask <= '1;
    end else if (reg_write && address == ADDR_MASK) begin
      mask <= writedata[NUM_REQ-1:0];
    end
  end

`ifdef NOC_ARB_STATS_EN
  logic [31:0] stat_words;

  // A clear in the same cycle as a delivery wins.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_words <= '0;
    end else if (reg_write && address == ADDR_STATS) begin
      stat_words <= '0;
    end else if (out_valid && out_ready) begin
      stat_words <= stat_words + 32'd1;
    end
  end

  assign stats_rd = stat_words;
`else
  assign stats_rd = '0;
`endif

  always_comb begin
    readdata = '0;
    case (address)
      ADDR_MASK:   readdata[NUM_REQ-1:0] = mask;
      ADDR_STATUS: begin
        readdata[STATUS_BUSY_BIT]   = (state == STREAM);
        readdata[STATUS_OVALID_BIT] = out_valid;
        readdata[IDX_W-1:0]         = grant;
      end
      ADDR_STATS:  readdata = stats_rd;
      default:     readdata = '0;
    endcase
  end

  logic unused_wdata;
  assign unused_wdata = ^writedata[31:NUM_REQ];

endmodule

// File: tb/tb_noc_out_arbiter.sv
// Scoreboard bench for noc_out_arbiter: per-requester packet stores, a
// packet-level round-robin model feeding an expected-word queue, and a monitor.
module tb_noc_out_arbiter;
  import noc_arb_pkg::*;

  localparam int NUM_REQ = 4;
  localparam int DATA_W  = 32;
  localparam int DEPTH   = 256;

  logic                      clk = 1'b0;
  logic                      reset_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ*DATA_W-1:0] req_data;
  logic [NUM_REQ-1:0]        req_last;
  logic [NUM_REQ-1:0]        req_ready;
  logic [DATA_W-1:0]         out_port;
  logic                      out_valid;
  logic                      out_ready;
  logic [1:0]                address;
  logic                      chipselect;
  logic                      write_n;
  logic [31:0]               writedata;
  logic [31:0]               readdata;

  noc_out_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_last   (req_last),
    .req_ready  (req_ready),
    .out_port   (out_port),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .address    (address),
    .chipselect (chipselect),
    .write_n    (write_n),
    .writedata  (writedata),
    .readdata   (readdata)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  logic [31:0] wmem [NUM_REQ][DEPTH];
  bit          lmem [NUM_REQ][DEPTH];
  int          wtail [NUM_REQ];
  int          whead [NUM_REQ];
  int          mhead [NUM_REQ];
  bit          mid   [NUM_REQ];
  int          acc_cnt [NUM_REQ];

  logic [31:0] exp_q [$];
  int          acc_log [$];
  int          del_log [$];
  int          model_last = NUM_REQ - 1;
  bit          gap_en = 0, rand_ready = 0, watch_r1 = 0;
  int          ready1_seen = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic add_word(input int r, input logic [31:0] d, input bit l);
    wmem[r][wtail[r]] = d;
    lmem[r][wtail[r]] = l;
    wtail[r]++;
  endtask

  // Packet-level round robin over pending packets of enabled requesters.
  task automatic model_run(input logic [NUM_REQ-1:0] m);
    bit found;
    bit l;
    do begin
      found = 0;
      for (int k = 1; k <= NUM_REQ && !found; k++) begin
        int j;
        j = (model_last + k) % NUM_REQ;
        if (m[j] && mhead[j] < wtail[j]) begin
          found = 1;
          do begin
            l = lmem[j][mhead[j]];
            exp_q.push_back(wmem[j][mhead[j]]);
            mhead[j]++;
          end while (!l);
          model_last = j;
        end
      end
    end while (found);
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #3;
    end
  endtask

  task automatic av_write(input logic [1:0] a, input logic [31:0] d);
    address = a; writedata = d; chipselect = 1'b1; write_n = 1'b0;
    @(posedge clk);
    #3;
    chipselect = 1'b0; write_n = 1'b1;
  endtask

  task automatic av_read(input logic [1:0] a, output logic [31:0] d);
    address = a; chipselect = 1'b1; write_n = 1'b1;
    #1;
    d = readdata;
    chipselect = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    int t;
    bit busy;
    t = 0;
    busy = 1;
    while (busy && t < 2000) begin
      tick(1);
      t++;
      busy = (exp_q.size() != 0) || out_valid;
      for (int i = 0; i < NUM_REQ; i++) if (whead[i] < wtail[i]) busy = 1;
    end
    check(name, 32'(busy), 32'd0);
    if (busy) exp_q.delete();
  endtask

  // Requester driver: samples handshakes at negedge, updates after posedge.
  initial begin
    bit fire [NUM_REQ];
    req_valid = '0; req_data = '0; req_last = '0;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NUM_REQ; i++) begin
        fire[i] = reset_n && req_valid[i] && req_ready[i];
        if (fire[i]) acc_log.push_back(cyc);
      end
      if (watch_r1 && req_ready[1]) ready1_seen++;
      @(posedge clk);
      #1;
      for (int i = 0; i < NUM_REQ; i++) begin
        if (fire[i] && reset_n && whead[i] < wtail[i]) begin
          mid[i] = !lmem[i][whead[i]];
          whead[i]++;
          acc_cnt[i]++;
        end
        if (whead[i] < wtail[i]) begin
          req_valid[i] = !(gap_en && mid[i] && $urandom_range(0, 2) == 0);
          req_data[i*DATA_W +: DATA_W] = wmem[i][whead[i]];
          req_last[i] = lmem[i][whead[i]];
        end else begin
          req_valid[i] = 1'b0;
          req_data[i*DATA_W +: DATA_W] = '0;
          req_last[i] = 1'b0;
        end
      end
      if (rand_ready) out_ready = ($urandom_range(0, 3) != 0);
    end
  end

  // Monitor: every delivered word must be the next expected one.
  initial begin
    forever begin
      @(negedge clk);
      if (reset_n && out_valid && out_ready) begin
        del_log.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_word: got 0x%08h with no word expected (cycle %0d)", out_port, cyc);
        end else begin
          check("out_word", out_port, exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int base, t;
    out_ready = 1'b1; address = '0; chipselect = 1'b0; write_n = 1'b1; writedata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      wtail[i] = 0; whead[i] = 0; mhead[i] = 0; mid[i] = 0; acc_cnt[i] = 0;
    end
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #11;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_out_port", out_port, 32'd0);
    check("rst_req_ready", 32'(req_ready), 32'd0);
    av_read(ADDR_MASK, rd);   check("rst_mask", rd, 32'hF);
    av_read(ADDR_STATUS, rd); check("rst_status", rd, 32'd0);
    reset_n = 1'b1;
    tick(2);

    // Single 3-word packet, back-to-back with one-cycle latency.
    acc_log.delete(); del_log.delete();
    add_word(0, 32'hA1, 0); add_word(0, 32'hA2, 0); add_word(0, 32'hA3, 1);
    model_run(4'hF);
    wait_drain("t1_drain");
    check("t1_acc_count", acc_log.size(), 3);
    check("t1_del_count", del_log.size(), 3);
    if (acc_log.size() == 3 && del_log.size() == 3) begin
      for (int k = 0; k < 3; k++) begin
        check("t1_latency", del_log[k], acc_log[k] + 1);
        check("t1_no_gap", acc_log[k], acc_log[0] + k);
      end
    end
    av_read(ADDR_STATUS, rd); check("t1_status_idle", rd, 32'd0);
    tick(1);

    // Mask excludes req1; mask reopened while req3 streams.
    av_write(ADDR_MASK, 32'hD);
    av_read(ADDR_MASK, rd); check("t4_mask_rd", rd, 32'hD);
    tick(1);
    ready1_seen = 0; watch_r1 = 1;
    base = acc_cnt[3];
    add_word(1, 32'hB1, 0); add_word(1, 32'hB2, 1);
    for (int k = 0; k < 6; k++) add_word(3, 32'hD0 + k, k == 5);
    model_run(4'hD);
    t = 0;
    while (acc_cnt[3] == base && t < 100) begin tick(1); t++; end
    check("t4_req3_started", 32'(acc_cnt[3] > base), 32'd1);
    av_write(ADDR_MASK, 32'hF);
    watch_r1 = 0;
    check("t4_req1_not_ready", ready1_seen, 0);
    model_run(4'hF);
    wait_drain("t4_drain");

    // Back-pressure: first word must hold while the sink stalls.
    out_ready = 1'b0;
    add_word(0, 32'hA1, 0); add_word(0, 32'hA2, 0); add_word(0, 32'hA3, 1);
    model_run(4'hF);
    t = 0;
    while (!out_valid && t < 50) begin tick(1); t++; end
    check("t3_loaded", 32'(out_valid), 32'd1);
    repeat (5) begin
      check("t3_port_hold", out_port, 32'hA1);
      check("t3_valid_hold", 32'(out_valid), 32'd1);
      check("t3_ready0_low", 32'(req_ready[0]), 32'd0);
      tick(1);
    end
    out_ready = 1'b1;
    wait_drain("t3_drain");

    // Randomized packets from all requesters with gaps and sink stalls.
    gap_en = 1; rand_ready = 1;
    for (int round = 0; round < 4; round++) begin
      for (int i = 0; i < NUM_REQ; i++) begin
        int np;
        np = $urandom_range(0, 2);
        for (int p = 0; p < np; p++) begin
          int len;
          len = $urandom_range(1, 4);
          for (int w = 0; w < len; w++) add_word(i, $urandom, w == len - 1);
        end
      end
      model_run(4'hF);
      wait_drain("rand_drain");
    end
    gap_en = 0; rand_ready = 0;
    tick(1);
    out_ready = 1'b1;
    tick(2);

    // Delivered-word statistics.
    av_write(ADDR_STATS, 32'd0);
    for (int k = 0; k < 7; k++) add_word(1, 32'h5700 + k, k == 6);
    model_run(4'hF);
    wait_drain("stats_drain");
    av_read(ADDR_STATS, rd);
`ifdef NOC_ARB_STATS_EN
    check("stats_count", rd, 32'd7);
`else
    check("stats_count", rd, 32'd0);
`endif
    tick(1);
    av_write(ADDR_STATS, 32'h1234);
    av_read(ADDR_STATS, rd); check("stats_cleared", rd, 32'd0);
    tick(1);

    // Reset in the middle of a 4-word packet.
    av_write(ADDR_MASK, 32'h5);
    tick(1);
    base = acc_cnt[2];
    for (int k = 0; k < 4; k++) add_word(2, 32'hC1 + k, k == 3);
    model_run(4'h5);
    t = 0;
    while (acc_cnt[2] < base + 2 && t < 100) begin tick(1); t++; end
    check("rst_mid_reached", 32'(acc_cnt[2] - base), 32'd2);
    reset_n = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      whead[i] = wtail[i]; mhead[i] = wtail[i]; mid[i] = 0;
    end
    exp_q.delete();
    model_last = NUM_REQ - 1;
    #1;
    check("rst_mid_out_valid", 32'(out_valid), 32'd0);
    check("rst_mid_out_port", out_port, 32'd0);
    check("rst_mid_req_ready", 32'(req_ready), 32'd0);
    av_read(ADDR_MASK, rd);   check("rst_mid_mask", rd, 32'hF);
    av_read(ADDR_STATUS, rd); check("rst_mid_status", rd, 32'd0);
    tick(2);
    reset_n = 1'b1;
    tick(2);

    // Two competing packets after reset: req1 then req2 with one bubble.
    acc_log.delete(); del_log.delete();
    add_word(1, 32'hE1, 0); add_word(1, 32'hE2, 1);
    add_word(2, 32'hF1, 0); add_word(2, 32'hF2, 1);
    model_run(4'hF);
    wait_drain("t2_drain");
    check("t2_acc_count", acc_log.size(), 4);
    if (acc_log.size() == 4) begin
      check("t2_pkt1_gap", acc_log[1], acc_log[0] + 1);
      check("t2_bubble", acc_log[2], acc_log[1] + 2);
      check("t2_pkt2_gap", acc_log[3], acc_log[2] + 1);
    end
    tick(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/noc_out_arbiter.md
Name: noc_out_arbiter

Overview:
Round-robin arbiter that shares one 32-bit NoC output word port between NUM_REQ on-chip requesters.
- Each requester presents word-granular packets on a valid/ready handshake, with a last flag.
- The block locks the grant for a whole packet and registers each accepted word onto out_port.
- A small Avalon-MM slave (2-bit address, zero-wait read mux) provides an enable mask, status and optional statistics to the Nios.

Parameters:
- NUM_REQ, 4, number of requesters (2..8)
- DATA_W, 32, NoC word width
- IDX_W, $clog2(NUM_REQ), grant index width (derived)

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester word valid
- req_data  in  NUM_REQ*DATA_W  packed words; requester i occupies bits [i*DATA_W +: DATA_W]
- req_last  in  NUM_REQ  marks final word of packet
- req_ready  out  NUM_REQ  per-requester word accepted this cycle when valid&ready
- out_port  out  DATA_W  registered NoC word
- out_valid  out  1  out_port holds an unsent word
- out_ready  in  1  NoC sink accepts out_port this cycle
- address  in  2  Avalon register select
- chipselect  in  1  Avalon chip select
- write_n  in  1  Avalon write strobe, active low
- writedata  in  32  Avalon write data
- readdata  out  32  Avalon read data, combinational from address

Behaviour:
- Clocking and reset:
  - Single clock domain. Asynchronous active-low reset.
  - Reset values: state=IDLE, out_valid=0, out_port=0, req_ready=0, enable mask=all ones, last_grant=NUM_REQ-1 (so requester 0 wins first), counters=0.
- FSM states: IDLE, STREAM.
  - IDLE:
    - Eligible set = req_valid & mask.
    - If the eligible set is non-empty, register grant = first eligible index searching from (last_grant+1) mod NUM_REQ upward with wrap-around, then go to STREAM.
    - req_ready=0 throughout IDLE, so there is one arbitration bubble per packet.
  - STREAM:
    - req_ready[grant] = (!out_valid | out_ready). All other req_ready bits are 0.
    - On accept, out_port<=req_data[grant] and out_valid<=1.
    - If an accepted word has req_last=1: last_grant<=grant, go to IDLE.
- Latency: a word accepted in cycle t appears on out_port in cycle t+1.
- Output register:
  - out_valid clears on out_ready when no new word is loaded in the same cycle.
  - Simultaneous drain and load gives full throughput of one word per cycle.
  - out_port is held stable while out_valid=1 and out_ready=0.
- Packet lock: the grant never changes mid-packet, even if the granted requester drops valid; the FSM waits in STREAM.
- Mask:
  - Writes take effect at the next IDLE decision only and never abort a packet in progress.
  - If mask=0, the block stays in IDLE.
- Registers, written when chipselect & ~write_n:
  - addr0: mask[NUM_REQ-1:0], read/write.
  - addr1: status, read-only = {busy(bit31)=state==STREAM, out_valid(bit30), zeros, grant[IDX_W-1:0]}.
  - addr2: statistics (see Optional Feature).
  - addr3: reads 0.
  - Writes to read-only addresses are ignored.
- Reset mid-packet: everything returns to reset values immediately. The partial packet is dropped and it is the requester's responsibility to resend it.

Optional Feature:
- Macro NOC_ARB_STATS_EN.
- When defined:
  - addr2 reads a 32-bit wrapping count of words delivered (out_valid&out_ready).
  - Any write to addr2 clears the count. If the clear coincides with a delivery, the clear wins.
- When undefined: no counter logic; addr2 reads 0 and writes are ignored.

Decomposition:
- Shared package noc_arb_pkg holds:
  - state enum (IDLE, STREAM)
  - register address constants (ADDR_MASK=0, ADDR_STATUS=1, ADDR_STATS=2)
  - status bit positions
- One natural sub-module: noc_rr_pick, a combinational rotate/priority-encode returning the first set bit of a request vector at or after a start index.

Test Plan:
- Requester 0 sends a 3-word packet 0xA1,0xA2,0xA3(last) with out_ready=1 -> words appear on out_port cycles t+1..t+3 after first accept, with no gaps; busy drops after the last word.
- Requesters 1 and 2 both hold 2-word packets after reset -> order is req1 packet then req2 packet, never interleaved, with one idle cycle between packets.
- Req0 streaming, out_ready held 0 for 5 cycles -> out_port stays 0xA1, out_valid=1, req_ready[0]=0; resumes with no word lost or duplicated.
- Write mask=0b1101, req1 and req3 valid with last_grant=0 -> req3 granted, req1 never readied; mask write during a req3 packet does not truncate it.
- Assert reset_n low mid-packet (2nd of 4 words) -> out_valid=0, out_port=0, req_ready=0 and mask=all ones within the reset cycle; next packet arbitrates from requester 0.
- With NOC_ARB_STATS_EN: deliver 7 words, read addr2 -> 7; write addr2 -> reads 0. Without the macro, addr2 always reads 0.
